// File: rtl/step_scheduler.sv
`timescale 1ns/1ps
// step_scheduler
// Front-end controller for the counter datapath. Two raw push-buttons are
// synchronised and debounced into one-cycle press events, which drive a mode
// FSM issuing single-cycle step pulses (manual, free-running auto, or burst).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   btn_step   in   raw step button (asynchronous, may bounce)
//   btn_mode   in   raw mode button (asynchronous, may bounce)
//   step_pulse out  one-cycle clock enable to the counter datapath
//   mode       out  00 MANUAL, 01 AUTO, 10 BURST
//   paused     out  AUTO mode is paused
//   burst_busy out  burst in progress
//   step_count out  step pulses issued, modulo 8
module step_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_PERIOD     = 8,
    parameter int unsigned BURST_LEN       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_step,
    input  logic       btn_mode,
    output logic       step_pulse,
    output logic [1:0] mode,
    output logic       paused,
    output logic       burst_busy,
    output logic [2:0] step_count
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TM_W = $clog2(AUTO_PERIOD);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_MAX = TM_W'(AUTO_PERIOD - 1);
    localparam logic [3:0]      BL_MAX = 4'(BURST_LEN);

    typedef enum logic [1:0] {
        MODE_MANUAL  = 2'b00,
        MODE_AUTO    = 2'b01,
        MODE_BURST   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_t;

    // Bit 0 carries the step button, bit 1 the mode button.
    logic [1:0]      sync1_r;
    logic [1:0]      sync2_r;
    logic [1:0]      deb_r;
    logic [1:0]      deb_d_r;
    logic [1:0]      press_r;
    logic [DB_W-1:0] dcnt_r [2];

    mode_t           mode_r;
    logic [TM_W-1:0] timer_r;
    logic [3:0]      bcnt_r;
    logic            paused_r;
    logic            busy_r;
    logic            pulse_r;
    logic [2:0]      count_r;

    logic            press_step_s;
    logic            press_mode_s;

    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_MANUAL: nxt = MODE_AUTO;
            MODE_AUTO:   nxt = MODE_BURST;
            default:     nxt = MODE_MANUAL;
        endcase
        return nxt;
    endfunction

    assign press_step_s = press_r[0];
    assign press_mode_s = press_r[1];

    // Synchronise, debounce and edge-detect both buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
            press_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                dcnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= {btn_mode, btn_step};
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            // Press is one cycle after the debounced level rises; releases are silent.
            press_r <= deb_r & ~deb_d_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    dcnt_r[i] <= '0;
                end else if (dcnt_r[i] == DB_MAX) begin
                    deb_r[i]  <= sync2_r[i];
                    dcnt_r[i] <= '0;
                end else begin
                    dcnt_r[i] <= dcnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Mode FSM, auto timer, burst sequencing, step pulse and step counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r   <= MODE_MANUAL;
            timer_r  <= '0;
            bcnt_r   <= 4'd0;
            paused_r <= 1'b0;
            busy_r   <= 1'b0;
            pulse_r  <= 1'b0;
            count_r  <= 3'd0;
        end else begin
            if (pulse_r) begin
                count_r <= count_r + 3'd1;
            end
            // A mode press pre-empts everything, including a same-cycle step press.
            if (press_mode_s) begin
                mode_r   <= next_mode(mode_r);
                timer_r  <= '0;
                bcnt_r   <= 4'd0;
                paused_r <= 1'b0;
                busy_r   <= 1'b0;
                pulse_r  <= 1'b0;
            end else begin
                case (mode_r)
                    MODE_MANUAL: begin
                        pulse_r <= press_step_s;
                    end
                    MODE_AUTO: begin
                        if (press_step_s) begin
                            paused_r <= ~paused_r;
                        end
                        // The toggle edge itself still runs on the old paused value.
                        if (paused_r) begin
                            pulse_r <= 1'b0;
                        end else if (timer_r == TM_MAX) begin
                            timer_r <= '0;
                            pulse_r <= 1'b1;
                        end else begin
                            timer_r <= timer_r + TM_W'(1);
                            pulse_r <= 1'b0;
                        end
                    end
                    MODE_BURST: begin
                        if (!busy_r) begin
                            if (press_step_s) begin
                                busy_r  <= 1'b1;
                                bcnt_r  <= 4'd1;
                                timer_r <= '0;
                                pulse_r <= 1'b1;
                            end else begin
                                pulse_r <= 1'b0;
                            end
                        end else if (bcnt_r == BL_MAX) begin
                            // Last pulse was issued the previous cycle.
                            busy_r  <= 1'b0;
                            bcnt_r  <= 4'd0;
                            timer_r <= '0;
                            pulse_r <= 1'b0;
                        end else if (timer_r == TM_MAX) begin
                            timer_r <= '0;
                            bcnt_r  <= bcnt_r + 4'd1;
                            pulse_r <= 1'b1;
                        end else begin
                            timer_r <= timer_r + TM_W'(1);
                            pulse_r <= 1'b0;
                        end
                    end
                    default: begin
                        mode_r   <= MODE_MANUAL;
                        timer_r  <= '0;
                        bcnt_r   <= 4'd0;
                        paused_r <= 1'b0;
                        busy_r   <= 1'b0;
                        pulse_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step_pulse = pulse_r;
    assign mode       = mode_r;
    assign paused     = paused_r;
    assign burst_busy = busy_r;
    assign step_count = count_r;

endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
Front-end controller for the counter datapath (ripple counter and modulo divider). It debounces two raw push-buttons and turns them into single-cycle step pulses. Pulses are issued under one of three modes: manual single-step, free-running auto, or fixed-length burst. The step_pulse output is the single clock-enable that sequences the counters, replacing direct button clocking. step_count mirrors the 3-bit counter value for checking.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change (>=2)
AUTO_PERIOD, 8, cycles between step pulses in AUTO and BURST modes (>=2)
BURST_LEN, 5, pulses per burst (1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_step  input  1  raw step button, asynchronous, may bounce
btn_mode  input  1  raw mode button, asynchronous, may bounce
step_pulse  output  1  one-cycle enable to the counter datapath
mode  output  2  current mode: 00 MANUAL, 01 AUTO, 10 BURST (11 unused)
paused  output  1  AUTO mode paused
burst_busy  output  1  burst in progress
step_count  output  3  number of step pulses issued, modulo 8

Behaviour:
- Reset (reset=0): all flops clear immediately, independent of clk. Sync flops, debounce counters, debounced levels, timers and burst counter go to 0. step_pulse=0, mode=00, paused=0, burst_busy=0, step_count=0. Reset asserted mid-operation (mid-burst, mid-debounce) aborts everything. After release, the block starts in MANUAL with no pending events.
- Input conditioning, identical per button:
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized level differs from the debounced level, and clears to 0 on any matching sample.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the debounced level updates on the next edge.
  - A press event is a registered one-cycle pulse, asserted the cycle after the debounced level rises. Releases generate no event.
  - Latency: raw rising edge at cycle 0, held stable, gives a press event at cycle DEBOUNCE_CYCLES+3.
- Mode FSM (register mode):
  - A mode press advances MANUAL -> AUTO -> BURST -> MANUAL.
  - On any mode change: AUTO timer cleared, paused=0, burst aborted (burst_busy=0, burst counter cleared). No step_pulse occurs in the cycle the new mode takes effect.
  - Simultaneous mode press and step press in the same cycle: the mode press wins and the step press is discarded.
- MANUAL: a step press at cycle t gives step_pulse high at cycle t+1 for exactly one cycle. End-to-end latency is DEBOUNCE_CYCLES+4 cycles from the raw edge.
- AUTO:
  - Timer counts 0..AUTO_PERIOD-1 and wraps. step_pulse is asserted in the cycle the timer wraps, i.e. every AUTO_PERIOD cycles. First pulse occurs AUTO_PERIOD cycles after mode entry.
  - A step press toggles paused.
  - While paused the timer freezes and no pulses are issued. On resume, counting continues from the frozen value.
- BURST:
  - A step press while burst_busy=0 sets burst_busy=1 next cycle and asserts the first step_pulse in that same cycle.
  - Subsequent pulses follow every AUTO_PERIOD cycles until BURST_LEN pulses total have been issued.
  - burst_busy remains high through the cycle of the last pulse and drops the next cycle.
  - Step presses while burst_busy=1 are ignored (not queued).
- step_count increments by 1 on every step_pulse and wraps 7 -> 0. It is never altered by mode changes.
- step_pulse is never high for two consecutive cycles in any mode (guaranteed since AUTO_PERIOD >= 2).
- MODE 11 is unreachable. If it is entered (e.g. by upset), the next edge returns to MANUAL.

Test Plan:
Parameters for all cases: DEBOUNCE_CYCLES=4, AUTO_PERIOD=4, BURST_LEN=3.
1. Reset, then btn_step held high from cycle 0 -> exactly one step_pulse, at cycle 8; step_count=1; no further pulses while held or on release.
2. btn_step bounces (high 2 cycles, low 1, high 2, low) -> no press event, no step_pulse, step_count stays 0.
3. One mode press -> mode=01; pulses every 4 cycles. A step press gives paused=1 and no pulses for 20 cycles; a second press resumes with the phase preserved. 8 total pulses -> step_count wraps to 0.
4. Two mode presses -> mode=10. A step press gives 3 pulses spaced 4 cycles apart; burst_busy high for 9 cycles. A second step press during the burst -> ignored, still 3 pulses total.
5. Mode press mid-burst after pulse 1 -> mode=00, burst_busy=0 next cycle, no further pulses. A mode and step press landing in the same cycle -> mode advances, no step_pulse.
6. Drive reset=0 asynchronously between clock edges mid-burst -> all outputs 0 immediately. After release, mode=00 and step_count=0.
